ro_freq_meter: RTL and testbench
================================

RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 Parameter CH, default 4: number of ring-oscillator input channels, range 1..16.
REQ-002 Parameter CNT_W, default 16: edge-counter and result width.
REQ-003 Parameter GATE_W, default 16: gate-length width.
REQ-004 Port clk  input  1: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port enable  input  1: level start/run request, synchronous to clk.
REQ-007 Port gate_len  input  GATE_W: measurement window length in clk cycles.
REQ-008 Port ro_in  input  CH: ring-oscillator outputs, asynchronous to clk.
REQ-009 Port sel  input  max(1,$clog2(CH)): channel whose result drives out.
REQ-010 Port out  output  CNT_W: registered result of channel sel.
REQ-011 Port busy  output  1: high in any state other than IDLE.
REQ-012 Port done  output  1: one-cycle pulse marking a completed window.
REQ-013 Port ovf  output  1: registered overflow flag of channel sel.

Function
REQ-014 Each ro_in bit SHALL pass a 2-flop synchroniser plus an edge register; a rising edge SHALL be detected 3 clk cycles after the input rises.
REQ-015 FSM states SHALL be IDLE, GATE, LATCH, DONE.
REQ-016 IDLE->GATE when enable=1: all channel counters cleared, gate_len sampled; gate_len=0 SHALL be treated as 1.
REQ-017 GATE SHALL last exactly the sampled length in cycles; each channel counter SHALL increment by 1 per cycle with a detected edge.
REQ-018 GATE->LATCH after the last gate cycle; LATCH SHALL copy all counters (and overflow bits) into result registers in one cycle.
REQ-019 LATCH->DONE unconditionally; done=1 only during DONE.
REQ-020 DONE->GATE if enable=1 (continuous mode, counters cleared, gate_len resampled), else DONE->IDLE.
REQ-021 Edges detected in LATCH, DONE and IDLE SHALL NOT be counted; window period in continuous mode is gate_len+2 cycles.
REQ-022 enable=0 during GATE SHALL abort to IDLE next cycle: no done pulse, result registers unchanged.
REQ-023 out and ovf SHALL reflect result[sel] one cycle after sel changes or after LATCH; out SHALL not change during GATE.
REQ-024 Changes to gate_len outside the sampling cycle SHALL have no effect on the current window.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and clear synchronisers, counters, results, out, ovf, busy and done to 0.
REQ-026 Reset mid-window SHALL discard the window; after rst_n rises the block SHALL wait in IDLE until enable=1 is sampled.

Configuration
REQ-027 Macro RO_SATURATE_EN defined: each counter SHALL saturate at 2^CNT_W-1 and set a sticky per-channel overflow bit cleared at window start; ovf reports it.
REQ-028 RO_SATURATE_EN undefined: counters SHALL wrap modulo 2^CNT_W and ovf SHALL be tied to 0.

Verification
REQ-029 CH=4; ro_in[0] period 2 clk, gate_len=100, enable pulsed one window -> done once, out(sel=0)=50 ±1, busy low after DONE.
REQ-030 ro_in[1] period 10 clk, ro_in[2] static 0, gate_len=1000, continuous enable -> done every 1002 cycles; sel=1 reads 100 ±1, sel=2 reads 0.
REQ-031 gate_len=0, ro_in[0] period 2 -> GATE lasts 1 cycle, done 3 cycles after start, out in 0..1.
REQ-032 enable dropped at gate cycle 40 of 100 -> IDLE next cycle, no done, out keeps previous window value.
REQ-033 CNT_W=4, ro_in[0] period 2, gate_len=100 -> with RO_SATURATE_EN out=15, ovf=1; without, out=50 mod 16=2, ovf=0.
REQ-034 rst_n low for 1 cycle mid-GATE -> all outputs 0 asynchronously; no done until enable resampled and a full window completes.

Source files
------------

// File: rtl/ro_freq_meter.sv
// Gated edge counter for CH asynchronous ring-oscillator inputs, one result register per channel.
// Optional macro RO_SATURATE_EN: counters saturate and raise a sticky per-channel overflow flag.
module ro_freq_meter #(
   parameter int CH     = 4,
   parameter int CNT_W  = 16,
   parameter int GATE_W = 16,
   localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [GATE_W-1:0] gate_len,
   input  logic [CH-1:0]     ro_in,
   input  logic [SEL_W-1:0]  sel,
   output logic [CNT_W-1:0]  out,
   output logic              busy,
   output logic              done,
   output logic              ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GATE  = 2'd1,
      LATCH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

   state_t             state_r, state_s;
   logic               start_s;
   logic [CH-1:0]      sync1_r, sync2_r, sync3_r, edge_s;
   logic [GATE_W-1:0]  gate_left_r;
   logic [CNT_W-1:0]   cnt_r [CH];
   logic [CNT_W-1:0]   res_r [CH];
   logic [CNT_W-1:0]   out_r;
   logic               busy_r, done_r;

   // A rising edge is seen once it has crossed both synchroniser stages.
   assign edge_s = sync2_r & ~sync3_r;

   // Synchroniser chain plus edge-history register per channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= '0;
         sync2_r <= '0;
         sync3_r <= '0;
      end else begin
         sync1_r <= ro_in;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   // Window control next-state decode; start_s marks the cycle that opens a window.
   always_comb begin
      state_s = state_r;
      start_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (enable) begin
               state_s = GATE;
               start_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         GATE: begin
            if (!enable) begin
               state_s = IDLE;
            end else if (gate_left_r == GATE_ONE) begin
               state_s = LATCH;
            end else begin
               state_s = GATE;
            end
         end
         LATCH: state_s = DONE;
         DONE: begin
            if (enable) begin
               state_s = GATE;
               start_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register, registered status flags and remaining-gate counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         gate_left_r <= '0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != IDLE);
         done_r  <= (state_s == DONE);
         if (start_s) begin
            gate_left_r <= (gate_len == '0) ? GATE_ONE : gate_len;
         end else if (state_r == GATE) begin
            gate_left_r <= gate_left_r - GATE_ONE;
         end else begin
            gate_left_r <= gate_left_r;
         end
      end
   end

   // Per-channel edge counters, cleared at window start and snapshotted in LATCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            cnt_r[i] <= '0;
            res_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (start_s) begin
               cnt_r[i] <= '0;
            end else if ((state_r == GATE) && edge_s[i]) begin
`ifdef RO_SATURATE_EN
               cnt_r[i] <= (cnt_r[i] == '1) ? cnt_r[i] : (cnt_r[i] + CNT_ONE);
`else
               cnt_r[i] <= cnt_r[i] + CNT_ONE;
`endif
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
            res_r[i] <= (state_r == LATCH) ? cnt_r[i] : res_r[i];
         end
      end
   end

   // Result mux for the selected channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r <= '0;
      end else if (int'(sel) < CH) begin
         out_r <= res_r[sel];
      end else begin
         out_r <= '0;
      end
   end

`ifdef RO_SATURATE_EN
   logic [CH-1:0] sat_r, res_sat_r;
   logic          ovf_r;

   // Sticky overflow per channel: set when an edge arrives at full scale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_r     <= '0;
         res_sat_r <= '0;
         ovf_r     <= 1'b0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (start_s) begin
               sat_r[i] <= 1'b0;
            end else if ((state_r == GATE) && edge_s[i] && (cnt_r[i] == '1)) begin
               sat_r[i] <= 1'b1;
            end else begin
               sat_r[i] <= sat_r[i];
            end
         end
         res_sat_r <= (state_r == LATCH) ? sat_r : res_sat_r;
         ovf_r     <= (int'(sel) < CH) ? res_sat_r[sel] : 1'b0;
      end
   end

   assign ovf = ovf_r;
`else
   assign ovf = 1'b0;
`endif

   assign out  = out_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: window length, counts, abort, reset and counter-width behaviour.
module tb_ro_freq_meter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable, en_s;
   logic [15:0] gate_len;
   logic        ro0 = 1'b0, ro1 = 1'b0, ro3 = 1'b0;
   logic [3:0]  ro;
   logic [1:0]  ro_s;
   logic [1:0]  sel;
   logic        sel_s;
   logic [15:0] out;
   logic        busy, done, ovf;
   logic [3:0]  out_s;
   logic        busy_s, done_s, ovf_s;

   int total = 0;
   int bad   = 0;
   int lat, nd;
   logic [15:0] prev;

   assign ro   = {ro3, 1'b0, ro1, ro0};
   assign ro_s = {1'b0, ro0};

   ro_freq_meter #(.CH(4), .CNT_W(16), .GATE_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .gate_len(gate_len), .ro_in(ro),
      .sel(sel), .out(out), .busy(busy), .done(done), .ovf(ovf)
   );

   ro_freq_meter #(.CH(2), .CNT_W(4), .GATE_W(16)) dut_small (
      .clk(clk), .rst_n(rst_n), .enable(en_s), .gate_len(gate_len), .ro_in(ro_s),
      .sel(sel_s), .out(out_s), .busy(busy_s), .done(done_s), .ovf(ovf_s)
   );

   always #5 clk = ~clk;
   // Oscillators run off-phase from clk: ro0 period 2 clk, ro1 period 10 clk, ro3 period 6 clk.
   initial begin #2; forever #10 ro0 = ~ro0; end
   initial begin #7; forever #50 ro1 = ~ro1; end
   initial begin #4; forever #30 ro3 = ~ro3; end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
      total++;
      assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = -1;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            cyc = c;
            break;
         end
      end
   endtask

   task automatic count_done(input int n, output int d);
      d = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (done === 1'b1) d++;
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; en_s = 1'b0; gate_len = 16'd100; sel = 2'd0; sel_s = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out", out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single window, gate_len disturbed after sampling.
      enable = 1'b1;
      repeat (5) @(negedge clk);
      check("busy_gate", busy, 1);
      gate_len = 16'd7;
      wait_done(200, lat);
      check("lat_100", lat + 5, 102);
      enable = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check_rng("cnt_p2", out, 49, 51);
      check("ovf_p2", ovf, 0);
      count_done(20, nd);
      check("done_once", nd, 0);

      // Abort mid-window keeps the previous result.
      prev = out;
      gate_len = 16'd100;
      enable = 1'b1;
      repeat (40) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      count_done(150, nd);
      check("abort_nodone", nd, 0);
      check("abort_keep", out, prev);

      // Reset in the middle of a window.
      enable = 1'b1;
      repeat (30) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_out", out, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      count_done(20, nd);
      check("rst_nodone", nd, 0);
      check("rst_idle", busy, 0);
      enable = 1'b1;
      wait_done(200, lat);
      check("rst_lat", lat, 102);
      enable = 1'b0;
      @(negedge clk);
      check_rng("rst_cnt", out, 49, 51);

      // Zero gate length behaves as one cycle.
      gate_len = 16'd0;
      enable = 1'b1;
      wait_done(20, lat);
      check("lat_zero", lat, 3);
      enable = 1'b0;
      @(negedge clk);
      check_rng("cnt_zero", out, 0, 1);

      // Continuous mode with long gate.
      gate_len = 16'd1000;
      sel = 2'd1;
      enable = 1'b1;
      wait_done(1100, lat);
      check("lat_1000", lat, 1002);
      @(negedge clk);
      check_rng("cnt_p10", out, 99, 101);
      sel = 2'd2;
      @(negedge clk);
      check("cnt_static", out, 0);
      wait_done(1100, lat);
      check("period_cont", lat + 2, 1002);
      check("busy_cont", busy, 1);
      enable = 1'b0;
      @(negedge clk);
      check("cont_idle", busy, 0);

      // Narrow counter: saturate or wrap depending on build.
      gate_len = 16'd100;
      en_s = 1'b1;
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (done_s === 1'b1) begin
            lat = c;
            break;
         end
      end
      check("lat_small", lat, 102);
      en_s = 1'b0;
      @(negedge clk);
`ifdef RO_SATURATE_EN
      check("sat_out", out_s, 15);
      check("sat_ovf", ovf_s, 1);
`else
      check_rng("wrap_out", out_s, 1, 3);
      check("wrap_ovf", ovf_s, 0);
`endif
      check("small_idle", busy_s, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
